robm_keylock_gen: RTL and testbench
===================================

Name: robm_keylock_gen

Overview:
- Parametrised successor to the team's single-key robm locked controller.
- Same 7-state robm Mealy control function, with up to three key-gated lock points instead of one.
- Each lock point has a duplicate decoy state.
- A saturating wrong-key counter makes decoy outputs corrupt once the wrong key has been used DECOY_DEPTH times.
- Used as a locked-FSM benchmark in the obfuscation suite.

Parameters:
- NUM_LOCKS, 1, number of active lock points (1..3); lock i ≥ NUM_LOCKS is transparent.
- KEY_SLICE, 1, key bits per lock point.
- KEY_VALUE, all ones (NUM_LOCKS*KEY_SLICE bits), correct key.
- DECOY_DEPTH, 4, decoy entries tolerated before corruption (1..2^CNT_W-1).
- CNT_W, 4, width of the wrong-key counter.
- CORRUPT_MASK, 10'h0C3, XOR mask applied to y in decoy states once corrupted.

Ports:
- clk  in  1  clock; state and counter update on the falling edge.
- rst  in  1  asynchronous, active-high reset.
- x  in  12  inputs; x[k-1] is xk.
- key  in  NUM_LOCKS*KEY_SLICE  key; lock i uses key[i*KEY_SLICE +: KEY_SLICE].
- y  out  10  Mealy outputs; y[k-1] is yk.
- state_o  out  4  current state code.
- key_err  out  1  high when wrong-key count ≥ DECOY_DEPTH.

Behaviour:
- Reset (posedge rst, asynchronous): state=S1, count=0. While rst is high: y=0, key_err=0, state_o=1. Reset wins over any simultaneous clock edge.
- State codes: S1..S7 = 1..7, S6D=8, S7D=9, S2D=10. Any other code: y=0, next state S1.
- y defaults to 0. Only the bits listed below go high. All decode is combinational from state, x and key.
- S1, priority order:
  - ~x1: stay in S1.
  - x11&x12: y4, go to S2.
  - x11&~x12: y7,y8, go to S3.
  - ~x11&x12: x8 → y1,y2, S4; else x5 → y2,y3, S4; else x6 → y10, S5; else y4, S2.
  - ~x11&~x12: x10&x9 → y10, S5; x10&~x9 → y1,y2, S4; ~x10&x9 → y2,y3, S4; else y4, S2.
- S2: y5, go to S1.
- S3: y6. Next state S6 if lock0 matches, else S6D.
- S4:
  - x4: y4. Next state S2 if lock2 matches, else S2D.
  - ~x4: stay in S4.
- S5:
  - x12: y2,y9. Next state S7 if lock1 matches, else S7D.
  - ~x12: y2,y3, go to S4.
- S6 and S6D: x2&x3 → y1,y2, S4; x2&~x3 → y2,y3, S4; ~x2 → y4, S2.
- S7 and S7D: x7 → y2,y3, S4; ~x7: stay in the same state (S7 or S7D).
- S2D: y5, go to S1.
- Lock match: key slice i == KEY_VALUE slice i. Transparent locks always match.
- Counter:
  - Increments by 1 on every falling edge where the next state is a decoy and the current state is not that same decoy. A self-loop in S7D does not count.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Cleared only by rst.
- key_err = (count ≥ DECOY_DEPTH), combinational from the registered count.
- Corruption: in S6D, S7D and S2D, when key_err=1, y = decoded y XOR CORRUPT_MASK. Non-decoy states are never corrupted.
- Key changes take effect at the next lock decision. A key change mid-decoy does not leave the decoy early.
- Latency: y is combinational in the same cycle. The state change is visible after the next falling edge.

Test Plan:
- Correct key, NUM_LOCKS=3, x1=x11=1, x12=0 → S1 gives y=y7|y8 (10'h0C0), then S3 y6, then S6. count stays 0, key_err=0.
- Wrong lock0 (key[0]=0) → S3 goes to S6D. With x2=x3=1, y=y1|y2 uncorrupted; count=1.
- Wrong lock0 applied 4 times with DECOY_DEPTH=4 → key_err=1 on the 4th entry. Next S6D visit with x2=x3=1 gives y=10'h003^10'h0C3=10'h0C0.
- NUM_LOCKS=1, wrong key bits 1..2 → S5→S7 and S4→S2 are unaffected, count stays 0.
- Sit in S7D with x7=0 for 10 edges → count unchanged. Saturation: CNT_W=2, 5 decoy entries → count=3, no wrap.
- Assert rst mid-S6D with key_err=1 → immediately state_o=1, y=0, key_err=0. After release, S1 decode resumes.

Source files
------------

// File: rtl/robm_keylock_gen.sv
// rtl/robm_keylock_gen.sv - robm Mealy controller with up to three key-gated lock points and decoy states
module robm_keylock_gen #(
  parameter int                             NUM_LOCKS    = 1,
  parameter int                             KEY_SLICE    = 1,
  parameter logic [NUM_LOCKS*KEY_SLICE-1:0] KEY_VALUE    = '1,
  parameter int                             DECOY_DEPTH  = 4,
  parameter int                             CNT_W        = 4,
  parameter logic [9:0]                     CORRUPT_MASK = 10'h0C3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [11:0]                      x,
  input  logic [NUM_LOCKS*KEY_SLICE-1:0]   key,
  output logic [9:0]                       y,
  output logic [3:0]                       state_o,
  output logic                             key_err
);

  localparam logic [3:0] S1  = 4'd1;
  localparam logic [3:0] S2  = 4'd2;
  localparam logic [3:0] S3  = 4'd3;
  localparam logic [3:0] S4  = 4'd4;
  localparam logic [3:0] S5  = 4'd5;
  localparam logic [3:0] S6  = 4'd6;
  localparam logic [3:0] S7  = 4'd7;
  localparam logic [3:0] S6D = 4'd8;
  localparam logic [3:0] S7D = 4'd9;
  localparam logic [3:0] S2D = 4'd10;

  localparam logic [9:0] Y1  = 10'h001;
  localparam logic [9:0] Y2  = 10'h002;
  localparam logic [9:0] Y3  = 10'h004;
  localparam logic [9:0] Y4  = 10'h008;
  localparam logic [9:0] Y5  = 10'h010;
  localparam logic [9:0] Y6  = 10'h020;
  localparam logic [9:0] Y7  = 10'h040;
  localparam logic [9:0] Y8  = 10'h080;
  localparam logic [9:0] Y9  = 10'h100;
  localparam logic [9:0] Y10 = 10'h200;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DECOY_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [3:0]       state;
  logic [3:0]       state_nxt;
  logic [9:0]       y_dec;
  logic [CNT_W-1:0] count;
  logic [2:0]       lock_ok;
  logic             cur_decoy;
  logic             nxt_decoy;
  logic             enter_decoy;

  // Lock points beyond NUM_LOCKS are transparent; active ones compare their key slice.
  generate
    for (genvar i = 0; i < 3; i++) begin : g_lock
      if (i < NUM_LOCKS) begin : g_active
        assign lock_ok[i] = (key[i*KEY_SLICE +: KEY_SLICE] == KEY_VALUE[i*KEY_SLICE +: KEY_SLICE]);
      end else begin : g_transparent
        assign lock_ok[i] = 1'b1;
      end
    end
  endgenerate

  // Mealy decode of next state and raw outputs from the current state and inputs.
  always_comb begin
    y_dec     = 10'h000;
    state_nxt = S1;
    case (state)
      S1: begin
        if (!x[0]) begin
          state_nxt = S1;
        end else if (x[10] && x[11]) begin
          y_dec = Y4; state_nxt = S2;
        end else if (x[10]) begin
          y_dec = Y7 | Y8; state_nxt = S3;
        end else if (x[11]) begin
          if (x[7]) begin
            y_dec = Y1 | Y2; state_nxt = S4;
          end else if (x[4]) begin
            y_dec = Y2 | Y3; state_nxt = S4;
          end else if (x[5]) begin
            y_dec = Y10; state_nxt = S5;
          end else begin
            y_dec = Y4; state_nxt = S2;
          end
        end else begin
          if (x[9] && x[8]) begin
            y_dec = Y10; state_nxt = S5;
          end else if (x[9]) begin
            y_dec = Y1 | Y2; state_nxt = S4;
          end else if (x[8]) begin
            y_dec = Y2 | Y3; state_nxt = S4;
          end else begin
            y_dec = Y4; state_nxt = S2;
          end
        end
      end
      S2, S2D: begin
        y_dec = Y5; state_nxt = S1;
      end
      S3: begin
        y_dec = Y6; state_nxt = lock_ok[0] ? S6 : S6D;
      end
      S4: begin
        if (x[3]) begin
          y_dec = Y4; state_nxt = lock_ok[2] ? S2 : S2D;
        end else begin
          state_nxt = S4;
        end
      end
      S5: begin
        if (x[11]) begin
          y_dec = Y2 | Y9; state_nxt = lock_ok[1] ? S7 : S7D;
        end else begin
          y_dec = Y2 | Y3; state_nxt = S4;
        end
      end
      S6, S6D: begin
        if (x[1] && x[2]) begin
          y_dec = Y1 | Y2; state_nxt = S4;
        end else if (x[1]) begin
          y_dec = Y2 | Y3; state_nxt = S4;
        end else begin
          y_dec = Y4; state_nxt = S2;
        end
      end
      S7, S7D: begin
        if (x[6]) begin
          y_dec = Y2 | Y3; state_nxt = S4;
        end else begin
          state_nxt = state;
        end
      end
      default: begin
        y_dec = 10'h000; state_nxt = S1;
      end
    endcase
  end

  // Decoy bookkeeping: only a fresh entry into a decoy state counts as a wrong-key use.
  always_comb begin
    cur_decoy   = (state == S6D) || (state == S7D) || (state == S2D);
    nxt_decoy   = (state_nxt == S6D) || (state_nxt == S7D) || (state_nxt == S2D);
    enter_decoy = nxt_decoy && (state_nxt != state);
  end

  // State and saturating wrong-key counter advance on the falling edge.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state <= S1;
      count <= '0;
    end else begin
      state <= state_nxt;
      if (enter_decoy && (count != CNT_MAX)) begin
        count <= count + CNT_W'(1);
      end
    end
  end

  // Outputs: reset forces y quiet, decoy states corrupt y once the wrong key is overused.
  always_comb begin
    key_err = (count >= DEPTH_C);
    state_o = state;
    if (rst) begin
      y = 10'h000;
    end else if (cur_decoy && key_err) begin
      y = y_dec ^ CORRUPT_MASK;
    end else begin
      y = y_dec;
    end
  end

endmodule

// File: tb/tb_robm_keylock_gen.sv
// tb/tb_robm_keylock_gen.sv - self-checking bench for robm_keylock_gen against a behavioural model
module tb_robm_keylock_gen;

  logic        clk;
  logic        rst;
  logic [11:0] x;
  logic [2:0]  key0;
  logic [0:0]  key1;
  logic [9:0]  y0, y1;
  logic [3:0]  st0, st1;
  logic        ke0, ke1;

  int pass_cnt;
  int total_cnt;
  int fail_cnt;

  int m_state [2];
  int m_cnt   [2];
  int depth   [2] = '{4, 3};
  int cmax    [2] = '{15, 3};
  localparam logic [9:0] MASK = 10'h0C3;

  robm_keylock_gen #(
    .NUM_LOCKS(3), .KEY_SLICE(1), .KEY_VALUE(3'b111),
    .DECOY_DEPTH(4), .CNT_W(4), .CORRUPT_MASK(10'h0C3)
  ) u_dut0 (
    .clk(clk), .rst(rst), .x(x), .key(key0),
    .y(y0), .state_o(st0), .key_err(ke0)
  );

  robm_keylock_gen #(
    .NUM_LOCKS(1), .KEY_SLICE(1), .KEY_VALUE(1'b1),
    .DECOY_DEPTH(3), .CNT_W(2), .CORRUPT_MASK(10'h0C3)
  ) u_dut1 (
    .clk(clk), .rst(rst), .x(x), .key(key1),
    .y(y1), .state_o(st1), .key_err(ke1)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  function automatic logic [11:0] xb(int k);
    return 12'(1) << (k - 1);
  endfunction

  function automatic logic [9:0] yb(int k);
    return 10'(1) << (k - 1);
  endfunction

  function automatic bit is_decoy(int s);
    return (s == 8) || (s == 9) || (s == 10);
  endfunction

  // Lock outcomes per instance; unused lock points of the single-lock part always match.
  function automatic logic [2:0] lock_ok(int k);
    if (k == 0) return key0;
    return {2'b11, key1[0]};
  endfunction

  // Behavioural model of the robm control table, written directly from the state/transition rules.
  function automatic void decode(input int st, input logic [11:0] xv, input logic [2:0] ok,
                                 output int ns, output logic [9:0] yv);
    bit xk [1:12];
    for (int i = 1; i <= 12; i++) xk[i] = xv[i-1];
    yv = '0;
    ns = 1;
    if (st == 1) begin
      if (!xk[1]) ns = 1;
      else if (xk[11] && xk[12]) begin yv = yb(4); ns = 2; end
      else if (xk[11]) begin yv = yb(7) | yb(8); ns = 3; end
      else if (xk[12]) begin
        if (xk[8]) begin yv = yb(1) | yb(2); ns = 4; end
        else if (xk[5]) begin yv = yb(2) | yb(3); ns = 4; end
        else if (xk[6]) begin yv = yb(10); ns = 5; end
        else begin yv = yb(4); ns = 2; end
      end else begin
        if (xk[10] && xk[9]) begin yv = yb(10); ns = 5; end
        else if (xk[10]) begin yv = yb(1) | yb(2); ns = 4; end
        else if (xk[9]) begin yv = yb(2) | yb(3); ns = 4; end
        else begin yv = yb(4); ns = 2; end
      end
    end else if (st == 2 || st == 10) begin
      yv = yb(5); ns = 1;
    end else if (st == 3) begin
      yv = yb(6); ns = ok[0] ? 6 : 8;
    end else if (st == 4) begin
      if (xk[4]) begin yv = yb(4); ns = ok[2] ? 2 : 10; end
      else ns = 4;
    end else if (st == 5) begin
      if (xk[12]) begin yv = yb(2) | yb(9); ns = ok[1] ? 7 : 9; end
      else begin yv = yb(2) | yb(3); ns = 4; end
    end else if (st == 6 || st == 8) begin
      if (xk[2] && xk[3]) begin yv = yb(1) | yb(2); ns = 4; end
      else if (xk[2]) begin yv = yb(2) | yb(3); ns = 4; end
      else begin yv = yb(4); ns = 2; end
    end else if (st == 7 || st == 9) begin
      if (xk[7]) begin yv = yb(2) | yb(3); ns = 4; end
      else ns = st;
    end
  endfunction

  function automatic void model_out(input int k, output logic [9:0] yv, output int ns);
    decode(m_state[k], x, lock_ok(k), ns, yv);
    if (is_decoy(m_state[k]) && (m_cnt[k] >= depth[k])) yv = yv ^ MASK;
    if (rst) yv = '0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 1;
      m_cnt[k]   = 0;
    end
  endtask

  task automatic model_update();
    logic [9:0] yv;
    int ns;
    for (int k = 0; k < 2; k++) begin
      model_out(k, yv, ns);
      if (is_decoy(ns) && (ns != m_state[k]) && (m_cnt[k] < cmax[k])) m_cnt[k]++;
      m_state[k] = ns;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [9:0] ey;
    int ns;
    for (int k = 0; k < 2; k++) begin
      model_out(k, ey, ns);
      chk($sformatf("%s_y%0d", tag, k), (k == 0) ? y0 : y1, ey);
      chk($sformatf("%s_st%0d", tag, k), (k == 0) ? st0 : st1, m_state[k]);
      chk($sformatf("%s_ke%0d", tag, k), (k == 0) ? ke0 : ke1, (m_cnt[k] >= depth[k]) ? 1 : 0);
    end
  endtask

  task automatic sample(input logic [11:0] xv, input string tag);
    x = xv;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic advance();
    @(negedge clk);
    model_update();
    #1;
  endtask

  initial begin
    logic [11:0] xloop;
    bit stop;
    pass_cnt = 0; total_cnt = 0; fail_cnt = 0;
    x = '0; key0 = 3'b111; key1 = 1'b1;
    rst = 1'b1;
    model_reset();

    // Reset state, outputs held quiet while rst is high even with an active S1 input.
    #3;
    check_all("reset");
    chk("rst_state", st0, 1);
    x = xb(1) | xb(11);
    #1;
    chk("rst_y_gated", y0, 0);
    chk("rst_key_err", ke0, 0);
    @(negedge clk);
    #1 rst = 1'b0;

    // Correct key path S1 -> S3 -> S6.
    sample(xb(1) | xb(11), "ok_s1");
    chk("ok_s1_y", y0, 10'h0C0);
    advance();
    sample('0, "ok_s3");
    chk("ok_s3_y", y0, 10'h020);
    chk("ok_s3_st", st0, 3);
    advance();
    sample(xb(2) | xb(3), "ok_s6");
    chk("ok_s6_st", st0, 6);
    chk("ok_s6_ke", ke0, 0);
    advance();
    sample(xb(4), "ok_s4");
    advance();
    sample('0, "ok_s2");
    advance();

    // Single-lock part ignores key bits 1..2; 3-lock part lands in S7D and self-loops without counting.
    key0 = 3'b001;
    key1 = 1'b1;
    sample(xb(1) | xb(12) | xb(6), "l1_s1");
    chk("l1_s1_st", st0, 1);
    advance();
    sample(xb(12), "l1_s5");
    chk("l1_s5_y", y0, 10'h102);
    advance();
    chk("l1_s7d_st0", st0, 9);
    chk("l1_s7_st1", st1, 7);
    for (int i = 0; i < 10; i++) begin
      sample('0, "s7d_loop");
      advance();
    end
    chk("s7d_loop_st", st0, 9);
    chk("s7d_loop_ke", ke0, 0);
    sample(xb(7), "s7d_exit");
    advance();
    sample(xb(4), "l1_s4");
    advance();
    chk("l1_s2d_st0", st0, 10);
    chk("l1_s2_st1", st1, 2);
    chk("l1_ke1", ke1, 0);
    sample('0, "l1_s2");
    advance();

    // Fresh reset, then repeated wrong lock0 into S6D; the small counter must saturate, not wrap.
    #1 rst = 1'b1;
    model_reset();
    #1 rst = 1'b0;
    key0 = 3'b110;
    key1 = 1'b0;
    xloop = xb(1) | xb(2) | xb(3) | xb(4) | xb(11);
    stop = 1'b0;
    for (int v = 1; v <= 5 && !stop; v++) begin
      for (int s = 0; s < 5 && !stop; s++) begin
        sample(xloop, $sformatf("dec_v%0d_s%0d", v, s));
        if (s == 2) begin
          chk($sformatf("dec_v%0d_st", v), st0, 8);
          chk($sformatf("dec_v%0d_y", v), y0, (v >= 4) ? 10'h0C0 : 10'h003);
          chk($sformatf("dec_v%0d_ke0", v), ke0, (v >= 4) ? 1 : 0);
          chk($sformatf("dec_v%0d_ke1", v), ke1, (v >= 3) ? 1 : 0);
          if (v == 5) begin
            // Asynchronous reset in the middle of a corrupted decoy visit.
            #1 rst = 1'b1;
            #1;
            model_reset();
            chk("mid_rst_st", st0, 1);
            chk("mid_rst_y", y0, 0);
            chk("mid_rst_ke", ke0, 0);
            chk("mid_rst_ke1", ke1, 0);
            stop = 1'b1;
          end
        end
        if (!stop) advance();
      end
    end
    @(negedge clk);
    #1 rst = 1'b0;
    key0 = 3'b111;
    key1 = 1'b1;
    sample(xb(1) | xb(11), "resume");
    chk("resume_y", y0, 10'h0C0);
    chk("resume_st", st0, 1);
    advance();

    // Randomized walk with mostly-correct keys, checked every cycle against the model.
    for (int n = 0; n < 400; n++) begin
      for (int b = 0; b < 3; b++) key0[b] = ($urandom_range(0, 3) != 0);
      key1[0] = ($urandom_range(0, 3) != 0);
      sample(12'($urandom), "rand");
      advance();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
